// File: rtl/battleship_game_fsm.sv
// Two-player battleship game sequencer: placement, alternating shots, win.
// Hit lookup lives outside; this block only tracks turns and scores.
module battleship_game_fsm #(
  parameter int SHIPS_PER_PLAYER = 5,
  parameter int TOTAL_HIT_CELLS  = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       place_valid,
  input  logic       shot_valid,
  output logic       shot_ready,
  input  logic       result_valid,
  input  logic       result_hit,
  output logic [2:0] state,
  output logic [2:0] ships_placed,
  output logic [4:0] p1_hits,
  output logic [4:0] p2_hits
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    P1_PLACE = 3'd1,
    P2_PLACE = 3'd2,
    P1_TURN  = 3'd3,
    P2_TURN  = 3'd4,
    P1_WIN   = 3'd5,
    P2_WIN   = 3'd6
  } state_t;

  localparam logic [2:0] LAST_SHIP = 3'(SHIPS_PER_PLAYER - 1);
  localparam logic [4:0] WIN_HITS  = 5'(TOTAL_HIT_CELLS);

  state_t     st_q, st_d;
  logic [2:0] ships_q, ships_d;
  logic [4:0] p1_q, p1_d;
  logic [4:0] p2_q, p2_d;
  logic       out_q, out_d;

  logic       in_turn;
  logic       p1_shoots;
  logic       res_take;
  logic       shot_fire;
  logic [4:0] cur_hits;
  logic [4:0] nxt_hits;
  logic       won;

  assign in_turn   = (st_q == P1_TURN) || (st_q == P2_TURN);
  assign p1_shoots = (st_q == P1_TURN);

  // out_q splits these two, so a same-cycle result always wins
  assign shot_ready = in_turn && !out_q;
  assign shot_fire  = shot_ready && shot_valid;
  assign res_take   = in_turn && out_q && result_valid;

  assign cur_hits = p1_shoots ? p1_q : p2_q;
  assign nxt_hits = (result_hit && (cur_hits < WIN_HITS))
                  ? cur_hits + 5'd1 : cur_hits;
  assign won      = result_hit && (nxt_hits == WIN_HITS);

  always_comb begin
    st_d    = st_q;
    ships_d = ships_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    out_d   = out_q;
    unique case (st_q)
      IDLE: begin
        if (start) begin
          st_d    = P1_PLACE;
          ships_d = '0;
          p1_d    = '0;
          p2_d    = '0;
          out_d   = 1'b0;
        end
      end
      P1_PLACE, P2_PLACE: begin
        if (place_valid) begin
          if (ships_q == LAST_SHIP) begin
            ships_d = '0;
            st_d    = (st_q == P1_PLACE) ? P2_PLACE : P1_TURN;
          end else begin
            ships_d = ships_q + 3'd1;
          end
        end
      end
      P1_TURN, P2_TURN: begin
        if (res_take) begin
          out_d = 1'b0;
          if (p1_shoots) p1_d = nxt_hits;
          else           p2_d = nxt_hits;
          if (won) st_d = p1_shoots ? P1_WIN : P2_WIN;
          else     st_d = p1_shoots ? P2_TURN : P1_TURN;
        end else if (shot_fire) begin
          out_d = 1'b1;
        end
      end
      P1_WIN, P2_WIN: begin
        if (start) st_d = IDLE;
      end
      default: begin
        st_d    = IDLE;
        ships_d = '0;
        p1_d    = '0;
        p2_d    = '0;
        out_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      ships_q <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      out_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      ships_q <= ships_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      out_q   <= out_d;
    end
  end

  assign state        = st_q;
  assign ships_placed = ships_q;
  assign p1_hits      = p1_q;
  assign p2_hits      = p2_q;

endmodule

// File: tb/tb_battleship_game_fsm.sv
// Bench for battleship_game_fsm: directed scenarios, then random play
// compared every cycle against a rule-level game model.
module tb_battleship_game_fsm;

  localparam int SHIPS = 5;
  localparam int TOT   = 17;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       place_valid = 1'b0;
  logic       shot_valid = 1'b0;
  logic       shot_ready;
  logic       result_valid = 1'b0;
  logic       result_hit = 1'b0;
  logic [2:0] state;
  logic [2:0] ships_placed;
  logic [4:0] p1_hits;
  logic [4:0] p2_hits;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // game model: phase, ships placed, scores, shot outstanding
  int ms = 0;
  int mp = 0;
  int m1 = 0;
  int m2 = 0;
  bit mo = 1'b0;

  battleship_game_fsm #(
    .SHIPS_PER_PLAYER(SHIPS),
    .TOTAL_HIT_CELLS (TOT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .place_valid (place_valid),
    .shot_valid  (shot_valid),
    .shot_ready  (shot_ready),
    .result_valid(result_valid),
    .result_hit  (result_hit),
    .state       (state),
    .ships_placed(ships_placed),
    .p1_hits     (p1_hits),
    .p2_hits     (p2_hits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ms = 0;
    mp = 0;
    m1 = 0;
    m2 = 0;
    mo = 1'b0;
  endtask

  function automatic bit model_ready();
    return (ms == 3 || ms == 4) && !mo;
  endfunction

  task automatic model_clk(input bit st, input bit pv, input bit sv,
                           input bit rv, input bit rh);
    bit rdy;
    rdy = model_ready();
    case (ms)
      0: if (st) begin
        model_reset();
        ms = 1;
      end
      1, 2: if (pv) begin
        mp++;
        if (mp == SHIPS) begin
          mp = 0;
          ms = ms + 1;
        end
      end
      3: if (mo && rv) begin
        mo = 1'b0;
        if (rh && m1 < TOT) m1++;
        ms = (rh && m1 == TOT) ? 5 : 4;
      end else if (sv && rdy) mo = 1'b1;
      4: if (mo && rv) begin
        mo = 1'b0;
        if (rh && m2 < TOT) m2++;
        ms = (rh && m2 == TOT) ? 6 : 3;
      end else if (sv && rdy) mo = 1'b1;
      5, 6: if (st) ms = 0;
      default: model_reset();
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("state", int'(state), ms);
      chk("ships_placed", int'(ships_placed), mp);
      chk("p1_hits", int'(p1_hits), m1);
      chk("p2_hits", int'(p2_hits), m2);
      chk("shot_ready", int'(shot_ready), int'(model_ready()));
    end
  end

  task automatic cyc(input bit st, input bit pv, input bit sv,
                     input bit rv, input bit rh);
    start        = st;
    place_valid  = pv;
    shot_valid   = sv;
    result_valid = rv;
    result_hit   = rh;
    @(posedge clk);
    model_clk(st, pv, sv, rv, rh);
    @(negedge clk);
  endtask

  task automatic place_all();
    repeat (2 * SHIPS) cyc(0, 1, 0, 0, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_ships"}, int'(ships_placed), 0);
    chk({tag, "_p1"}, int'(p1_hits), 0);
    chk({tag, "_p2"}, int'(p2_hits), 0);
    chk({tag, "_ready"}, int'(shot_ready), 0);
  endtask

  initial begin
    int acc;
    #1;
    chk_reset_vals("por");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // placement sequence
    cyc(1, 0, 0, 0, 0);
    chk("start_state", int'(state), 1);
    for (int i = 0; i < SHIPS; i++) begin
      cyc(0, 1, 0, 0, 0);
      if (i < SHIPS - 1) chk("p1_place_cnt", int'(ships_placed), i + 1);
    end
    chk("p1_done_state", int'(state), 2);
    chk("p1_done_ships", int'(ships_placed), 0);
    repeat (SHIPS) cyc(0, 1, 0, 0, 0);
    chk("p2_done_state", int'(state), 3);

    // held shot_valid yields one acceptance
    acc = 0;
    repeat (3) begin
      if (shot_ready) acc++;
      cyc(0, 0, 1, 0, 0);
    end
    chk("accept_count", acc, 1);
    cyc(0, 0, 0, 1, 0);
    chk("miss_state", int'(state), 4);
    chk("miss_p1", int'(p1_hits), 0);
    chk("miss_ready", int'(shot_ready), 1);

    // stray result, then result racing a new shot
    cyc(0, 0, 0, 1, 1);
    chk("stray_state", int'(state), 4);
    chk("stray_p2", int'(p2_hits), 0);
    cyc(0, 0, 1, 0, 0);
    chk("p2_out_ready", int'(shot_ready), 0);
    cyc(0, 0, 1, 1, 0);
    chk("race_state", int'(state), 3);
    chk("race_ready", int'(shot_ready), 1);

    // P1 hits every shot, P2 always misses
    repeat (TOT - 1) begin
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 1);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0);
    end
    chk("pre_win_p1", int'(p1_hits), 16);
    chk("pre_win_state", int'(state), 3);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1);
    chk("win_p1", int'(p1_hits), 17);
    chk("win_state", int'(state), 5);
    cyc(0, 1, 1, 1, 1);
    chk("win_hold_state", int'(state), 5);
    chk("win_hold_p1", int'(p1_hits), 17);
    chk("win_hold_ready", int'(shot_ready), 0);
    cyc(1, 0, 0, 0, 0);
    chk("win_to_idle", int'(state), 0);

    // reset with a P2 shot outstanding
    cyc(1, 1, 0, 0, 0);
    chk("idle_start_wins", int'(ships_placed), 0);
    place_all();
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    chk("p2_pending_state", int'(state), 4);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_reset_vals("async");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 0, 1, 1);
    chk("post_rst_state", int'(state), 1);
    chk("post_rst_p2", int'(p2_hits), 0);

    // random play against the model
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk("rand_rst_state", int'(state), 0);
        #1 rst_n = 1'b1;
      end
      cyc($urandom_range(0, 39) == 0,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 2) != 0,
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 3) != 0);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/battleship_game_fsm.md
BATTLESHIP_GAME_FSM -- requirements
Module: battleship_game_fsm

Interface
REQ-001 Parameter SHIPS_PER_PLAYER, default 5: ship placements each player commits before play, range 1..7.
REQ-002 Parameter TOTAL_HIT_CELLS, default 17: ship cells per fleet; reaching this hit count wins, range 1..31.
REQ-003 clk  in  1  single system clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  single-cycle request to start or restart a game.
REQ-006 place_valid  in  1  single-cycle pulse: the current placing player committed one ship.
REQ-007 shot_valid  in  1  the current player offers a shot.
REQ-008 shot_ready  out  1  the FSM accepts a shot this cycle.
REQ-009 result_valid  in  1  single-cycle pulse: hit lookup result for the outstanding shot.
REQ-010 result_hit  in  1  qualified by result_valid; 1 = hit, 0 = miss.
REQ-011 state  out  3  game state encoding consumed by the placement-permission and display logic.
REQ-012 ships_placed  out  3  ships committed by the current placing player.
REQ-013 p1_hits  out  5  hits scored by player 1.
REQ-014 p2_hits  out  5  hits scored by player 2.

Function
REQ-015 The state encoding SHALL be IDLE=0, P1_PLACE=1, P2_PLACE=2, P1_TURN=3, P2_TURN=4, P1_WIN=5, P2_WIN=6; code 7 is illegal.
REQ-016 state SHALL be driven directly from a register; every transition becomes visible the cycle after the qualifying input is sampled.
REQ-017 IDLE SHALL go to P1_PLACE on start and clear ships_placed, p1_hits, p2_hits and the shot-outstanding flag.
REQ-018 In P1_PLACE and P2_PLACE, place_valid SHALL increment ships_placed by 1.
REQ-019 The placement that brings ships_placed to SHIPS_PER_PLAYER SHALL advance the state and clear ships_placed in the same cycle: P1_PLACE goes to P2_PLACE, and P2_PLACE goes to P1_TURN.
REQ-020 place_valid SHALL be ignored in all states other than P1_PLACE and P2_PLACE.
REQ-021 shot_ready SHALL be 1 only in P1_TURN or P2_TURN while no shot is outstanding.
REQ-022 A shot is accepted when shot_valid and shot_ready are both 1; acceptance SHALL set the outstanding flag, so shot_ready is 0 from the next cycle.
REQ-023 result_valid SHALL be ignored when no shot is outstanding.
REQ-024 When a shot is outstanding, result_valid SHALL clear the outstanding flag and resolve the turn as follows:
  - a hit increments the current shooter's counter;
  - if the new count equals TOTAL_HIT_CELLS, the state goes to the shooter's WIN state;
  - otherwise the state alternates: P1_TURN goes to P2_TURN and P2_TURN goes to P1_TURN, on both hit and miss.
REQ-025 If shot_valid and result_valid arrive in the same cycle, the result SHALL be processed and the shot SHALL NOT be accepted.
REQ-026 Hit counters SHALL saturate at TOTAL_HIT_CELLS and never wrap.
REQ-027 P1_WIN and P2_WIN SHALL hold, with the counters frozen, until start; start then goes to IDLE.
REQ-028 start SHALL be ignored in the placing and turn states.
REQ-029 If start and place_valid arrive together in IDLE, the FSM SHALL take start and ignore place_valid.
REQ-030 Illegal state code 7 SHALL return to IDLE on the next clock with all counters cleared.

Reset
REQ-031 While rst_n is 0, the block SHALL hold the following values immediately, independent of clk:
  - state=IDLE (0), ships_placed=0, p1_hits=0, p2_hits=0;
  - outstanding flag=0, shot_ready=0.
REQ-032 Assertion of rst_n mid-game, including with a shot outstanding, SHALL abandon the game; a result_valid arriving after release SHALL be ignored.
REQ-033 The first clock edge after rst_n rises SHALL sample inputs normally.

Verification
REQ-034 Placement: reset, start, then 5 place_valid pulses -> state 1 then 2, ships_placed steps 0..4 then returns to 0; 5 more pulses -> state=3.
REQ-035 Shot handshake: in state 3, hold shot_valid high -> exactly one acceptance; result_valid=1, result_hit=0 -> state=4, p1_hits=0, shot_ready=1 again.
REQ-036 Win: with p1_hits=16, a P1 shot returning a hit -> p1_hits=17, state=5; further place_valid, shot_valid and result_valid have no effect; start -> state=0.
REQ-037 Ignored inputs and same-cycle events:
  - result_valid with no shot outstanding -> no change to state or counters;
  - shot_valid and result_valid in the same cycle -> only the result is processed.
REQ-038 Reset mid-game: drop rst_n while a P2 shot is outstanding -> outputs equal the REQ-031 values without a clock; a result_valid after release is ignored.
